// File: rtl/ahblite_pkg.sv
// Shared AHB-lite encodings and types for the decode/mux slice.
package ahblite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    typedef struct packed {
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
    } ahb_rsp_t;

    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers, plus a
// saturating error counter and faulting-address capture.
module ahblite_default_slave
    import ahblite_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hready,
    input  logic                 def_sel,
    input  logic [1:0]           htrans,
    input  logic [31:0]          haddr,
    input  logic                 err_clr,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          err_addr
);

    ds_state_t state;
    logic      start;

    assign start = hready && def_sel && is_active(htrans);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DS_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            err_cnt   <= '0;
            err_addr  <= '0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (start) begin
                        state     <= DS_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (start) begin
                        state     <= DS_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                end
            endcase

            // Clear beats a coincident increment or capture.
            if (err_clr) begin
                err_cnt  <= '0;
                err_addr <= '0;
            end else begin
                if (state == DS_ERR2 && err_cnt != '1)
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                if (start && state != DS_ERR1)
                    err_addr <= haddr;
            end
        end
    end

endmodule

// File: rtl/ahblite_decode_mux.sv
// AHB-lite N-port address decoder, data-phase response mux and built-in
// default slave for unmapped or disabled regions.
module ahblite_decode_mux
    import ahblite_pkg::*;
#(
    parameter int                  NPORT     = 4,
    parameter int                  RGN_BITS  = 16,
    parameter logic [RGN_BITS-1:0] BASE_RGN  = 16'hC000,
    parameter logic [NPORT-1:0]    PORT_EN   = {NPORT{1'b1}},
    parameter int                  ERR_CNT_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL_M,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    output logic [NPORT-1:0]      P_HSEL,
    input  logic [NPORT-1:0]      P_HREADYOUT,
    input  logic [NPORT-1:0]      P_HRESP,
    input  logic [32*NPORT-1:0]   P_HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    input  logic                  ERR_CLR,
    output logic [ERR_CNT_W-1:0]  ERR_CNT,
    output logic [31:0]           ERR_ADDR
);

    localparam longint RGN_LAST = longint'(BASE_RGN) + longint'(NPORT) - 1;
    localparam longint RGN_MAX  = (longint'(1) << RGN_BITS) - 1;

    // Port regions must not wrap past the top of the compared field.
    if (RGN_LAST > RGN_MAX || NPORT < 1 || NPORT > 16 || RGN_BITS < 1 || RGN_BITS > 32) begin : g_cfg_err
        $error("ahblite_decode_mux: illegal NPORT/RGN_BITS/BASE_RGN combination");
    end

    logic [RGN_BITS-1:0] rgn;
    logic [NPORT-1:0]    hit;
    logic                def_sel;
    logic [NPORT:0]      dsel;
    logic                ds_hreadyout;
    logic                ds_hresp;
    ahb_rsp_t            rsp;

    assign rgn = HADDR[31:32-RGN_BITS];

    for (genvar i = 0; i < NPORT; i++) begin : g_dec
        localparam logic [RGN_BITS-1:0] RGN_I = RGN_BITS'(longint'(BASE_RGN) + longint'(i));
        assign hit[i] = HSEL_M && (rgn == RGN_I);
    end

    assign P_HSEL  = hit & PORT_EN;
    assign def_sel = HSEL_M && (P_HSEL == '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            dsel <= '0;
        else if (HREADY)
            dsel <= {def_sel, P_HSEL};
    end

    // dsel is one-hot or zero; zero means no data phase pending.
    always_comb begin
        rsp = '{hready: 1'b1, hresp: HRESP_OKAY, hrdata: 32'h0};
        for (int i = 0; i < NPORT; i++) begin
            if (dsel[i])
                rsp = '{hready: P_HREADYOUT[i], hresp: P_HRESP[i], hrdata: P_HRDATA[32*i +: 32]};
        end
        if (dsel[NPORT])
            rsp = '{hready: ds_hreadyout, hresp: ds_hresp, hrdata: 32'h0};
    end

    assign HREADY = rsp.hready;
    assign HRESP  = rsp.hresp;
    assign HRDATA = rsp.hrdata;

    ahblite_default_slave #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_def_slave (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .hready    (HREADY),
        .def_sel   (def_sel),
        .htrans    (HTRANS),
        .haddr     (HADDR),
        .err_clr   (ERR_CLR),
        .hreadyout (ds_hreadyout),
        .hresp     (ds_hresp),
        .err_cnt   (ERR_CNT),
        .err_addr  (ERR_ADDR)
    );

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Self-checking bench for ahblite_decode_mux: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ahblite_decode_mux;

    localparam int              NPORT   = 4;
    localparam logic [NPORT-1:0] PORT_EN = 4'b1101;

    logic                    HCLK = 1'b0;
    logic                    HRESETn;
    logic                    HSEL_M;
    logic [31:0]             HADDR;
    logic [1:0]              HTRANS;
    logic [NPORT-1:0]        P_HSEL;
    logic [NPORT-1:0]        P_HREADYOUT;
    logic [NPORT-1:0]        P_HRESP;
    logic [NPORT-1:0][31:0]  p_hrdata;
    logic                    HREADY;
    logic                    HRESP;
    logic [31:0]             HRDATA;
    logic                    ERR_CLR;
    logic [7:0]              ERR_CNT;
    logic [31:0]             ERR_ADDR;

    int checks   = 0;
    int failures = 0;

    ahblite_decode_mux #(
        .NPORT     (NPORT),
        .RGN_BITS  (16),
        .BASE_RGN  (16'hC000),
        .PORT_EN   (PORT_EN),
        .ERR_CNT_W (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL_M      (HSEL_M),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .P_HSEL      (P_HSEL),
        .P_HREADYOUT (P_HREADYOUT),
        .P_HRESP     (P_HRESP),
        .P_HRDATA    (p_hrdata),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .ERR_CLR     (ERR_CLR),
        .ERR_CNT     (ERR_CNT),
        .ERR_ADDR    (ERR_ADDR)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSEL_M      = 1'b0;
        HADDR       = 32'h0;
        HTRANS      = 2'd0;
        ERR_CLR     = 1'b0;
        P_HREADYOUT = '1;
        P_HRESP     = '0;
        for (int i = 0; i < NPORT; i++) p_hrdata[i] = 32'hDEAD_0000 | 32'(i);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t);
        HSEL_M = 1'b1;
        HADDR  = a;
        HTRANS = t;
    endtask

    task automatic apply_reset();
        HRESETn = 1'b0;
        idle_bus();
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle_bus();
        #3;
        checks++; if (HREADY !== 1'b1) begin failures++; $display("FAIL rst_hready_in_reset got=%b exp=1", HREADY); end
        tick();
        tick();
        HRESETn = 1'b1;
        #2;
        checks++; if (HREADY !== 1'b1) begin failures++; $display("FAIL rst_hready got=%b exp=1", HREADY); end
        checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL rst_hresp got=%b exp=0", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
        checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL rst_err_cnt got=%0d exp=0", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'h0) begin failures++; $display("FAIL rst_err_addr got=%h exp=0", ERR_ADDR); end
        checks++; if (P_HSEL !== 4'b0000) begin failures++; $display("FAIL rst_p_hsel got=%b exp=0000", P_HSEL); end
    endtask

    task automatic test_read();
        tick();
        addr_phase(32'hC002_0010, 2'd2);
        #2;
        checks++; if (P_HSEL !== 4'b0100) begin failures++; $display("FAIL read_p_hsel got=%b exp=0100", P_HSEL); end
        tick();
        idle_bus();
        P_HREADYOUT[2] = 1'b0;
        #2;
        checks++; if (HREADY !== 1'b0) begin failures++; $display("FAIL read_wait_hready got=%b exp=0", HREADY); end
        tick();
        P_HREADYOUT[2] = 1'b1;
        p_hrdata[2]    = 32'hA5A5_0002;
        #2;
        checks++; if (HREADY !== 1'b1) begin failures++; $display("FAIL read_done_hready got=%b exp=1", HREADY); end
        checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL read_done_hresp got=%b exp=0", HRESP); end
        checks++; if (HRDATA !== 32'hA5A5_0002) begin failures++; $display("FAIL read_hrdata got=%h exp=a5a50002", HRDATA); end
        tick();
        idle_bus();
    endtask

    // One NONSEQ to an address that must land on the default slave.
    task automatic run_error(input string nm, input logic [31:0] a, input int exp_cnt);
        tick();
        addr_phase(a, 2'd2);
        #2;
        checks++; if (P_HSEL !== 4'b0000) begin failures++; $display("FAIL %s_p_hsel got=%b exp=0000", nm, P_HSEL); end
        tick();
        idle_bus();
        #2;
        checks++; if ({HREADY, HRESP} !== 2'b01) begin failures++; $display("FAIL %s_err1 got=%b exp=01", nm, {HREADY, HRESP}); end
        tick();
        #2;
        checks++; if ({HREADY, HRESP} !== 2'b11) begin failures++; $display("FAIL %s_err2 got=%b exp=11", nm, {HREADY, HRESP}); end
        tick();
        #2;
        checks++; if ({HREADY, HRESP} !== 2'b10) begin failures++; $display("FAIL %s_after got=%b exp=10", nm, {HREADY, HRESP}); end
        checks++; if (ERR_CNT !== 8'(exp_cnt)) begin failures++; $display("FAIL %s_err_cnt got=%0d exp=%0d", nm, ERR_CNT, exp_cnt); end
        checks++; if (ERR_ADDR !== a) begin failures++; $display("FAIL %s_err_addr got=%h exp=%h", nm, ERR_ADDR, a); end
    endtask

    task automatic test_unmapped();
        run_error("unmapped", 32'hC004_0000, 1);
    endtask

    task automatic test_disabled();
        run_error("disabled", 32'hC001_0000, 2);
    endtask

    task automatic test_back_to_back();
        int lows = 0;
        tick();
        addr_phase(32'hC004_0000, 2'd2);
        for (int k = 0; k < 600; k++) begin
            tick();
            #2;
            if (HREADY === 1'b0) lows++;
        end
        idle_bus();
        tick();
        #2;
        checks++; if (lows != 300) begin failures++; $display("FAIL b2b_wait_cycles got=%0d exp=300", lows); end
        checks++; if (ERR_CNT !== 8'd255) begin failures++; $display("FAIL b2b_saturate got=%0d exp=255", ERR_CNT); end
        // one more error whose increment coincides with ERR_CLR
        tick();
        addr_phase(32'hC00F_1234, 2'd3);
        tick();
        idle_bus();
        tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        #2;
        checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL clr_vs_inc_cnt got=%0d exp=0", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'h0) begin failures++; $display("FAIL clr_err_addr got=%h exp=0", ERR_ADDR); end
    endtask

    task automatic test_idle();
        tick();
        addr_phase(32'hC009_0000, 2'd0);
        #2;
        checks++; if (P_HSEL !== 4'b0000) begin failures++; $display("FAIL idle_p_hsel got=%b exp=0000", P_HSEL); end
        tick();
        addr_phase(32'hC009_0004, 2'd1);
        #2;
        checks++; if ({HREADY, HRESP} !== 2'b10) begin failures++; $display("FAIL idle_resp got=%b exp=10", {HREADY, HRESP}); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL idle_hrdata got=%h exp=0", HRDATA); end
        tick();
        idle_bus();
        #2;
        checks++; if ({HREADY, HRESP} !== 2'b10) begin failures++; $display("FAIL busy_resp got=%b exp=10", {HREADY, HRESP}); end
        tick();
        #2;
        checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL idle_err_cnt got=%0d exp=0", ERR_CNT); end
    endtask

    task automatic test_reset_mid();
        tick();
        addr_phase(32'hC004_0000, 2'd2);
        tick();
        idle_bus();
        #2;
        checks++; if (HREADY !== 1'b0) begin failures++; $display("FAIL midrst_err1 got=%b exp=0", HREADY); end
        HRESETn = 1'b0;
        #1;
        checks++; if ({HREADY, HRESP} !== 2'b10) begin failures++; $display("FAIL midrst_resp got=%b exp=10", {HREADY, HRESP}); end
        tick();
        HRESETn = 1'b1;
        tick();
        #2;
        checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL midrst_err_cnt got=%0d exp=0", ERR_CNT); end
    endtask

    // Reference model: tracks who owns the data phase and how many cycles
    // into a default-slave ERROR we are, from the bus rules alone.
    task automatic test_random();
        int owner, dcyc, ecnt, pidx, rfail;
        logic [31:0] eaddr;
        logic [15:0] rg;
        logic [3:0]  epsel;
        logic        er, eresp, defsel, start;
        logic [31:0] edata;
        apply_reset();
        owner = -1; dcyc = 0; ecnt = 0; eaddr = '0; rfail = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            HSEL_M = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 2))
                0:       rg = 16'hC000 + 16'($urandom_range(0, 3));
                1:       rg = 16'hC000 + 16'($urandom_range(4, 9));
                default: rg = 16'($urandom);
            endcase
            HADDR       = {rg, 16'($urandom)};
            HTRANS      = 2'($urandom_range(0, 3));
            ERR_CLR     = ($urandom_range(0, 19) == 0);
            P_HREADYOUT = 4'($urandom);
            P_HRESP     = 4'($urandom);
            for (int i = 0; i < NPORT; i++) p_hrdata[i] = $urandom;
            #2;
            epsel = '0; pidx = -1;
            if (HSEL_M && rg >= 16'hC000 && rg < 16'hC004 && PORT_EN[rg - 16'hC000]) begin
                pidx = int'(rg - 16'hC000);
                epsel[pidx] = 1'b1;
            end
            if (owner >= 0 && owner < NPORT) begin
                er = P_HREADYOUT[owner]; eresp = P_HRESP[owner]; edata = p_hrdata[owner];
            end else if (owner == NPORT) begin
                er = (dcyc != 1); eresp = (dcyc != 0); edata = 32'h0;
            end else begin
                er = 1'b1; eresp = 1'b0; edata = 32'h0;
            end
            checks++; if (P_HSEL !== epsel) begin failures++; $display("FAIL rnd_p_hsel n=%0d got=%b exp=%b", n, P_HSEL, epsel); end
            checks++; if (HREADY !== er) begin failures++; $display("FAIL rnd_hready n=%0d got=%b exp=%b", n, HREADY, er); end
            checks++; if (HRESP !== eresp) begin failures++; $display("FAIL rnd_hresp n=%0d got=%b exp=%b", n, HRESP, eresp); end
            checks++; if (HRDATA !== edata) begin failures++; $display("FAIL rnd_hrdata n=%0d got=%h exp=%h", n, HRDATA, edata); end
            checks++; if (ERR_CNT !== 8'(ecnt)) begin failures++; $display("FAIL rnd_err_cnt n=%0d got=%0d exp=%0d", n, ERR_CNT, ecnt); end
            checks++; if (ERR_ADDR !== eaddr) begin failures++; $display("FAIL rnd_err_addr n=%0d got=%h exp=%h", n, ERR_ADDR, eaddr); end
            defsel = HSEL_M && (epsel == '0);
            start  = er && defsel && HTRANS[1];
            if (ERR_CLR) begin
                ecnt = 0; eaddr = '0;
            end else begin
                if (dcyc == 2 && ecnt < 255) ecnt++;
                if (start) eaddr = HADDR;
            end
            dcyc = (dcyc == 1) ? 2 : (start ? 1 : 0);
            if (er) owner = (pidx >= 0) ? pidx : (defsel ? NPORT : -1);
        end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_read();
        test_unmapped();
        test_disabled();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahblite_decode_mux.md
Name: ahblite_decode_mux

Overview:
- Parametrised N-port AHB-lite slave-side decoder plus response multiplexer.
- Sits between one master's HSEL_M qualified bus and NPORT peripheral slaves.
- Address-phase decode generates per-port HSEL. A registered data-phase select steers HREADY/HRESP/HRDATA back from the selected slave.
- Adds a built-in default slave: unmapped or disabled regions get a two-cycle ERROR response. Errors are counted and the faulting address is captured.

Parameters:
- NPORT, 4, number of slave ports (1..16).
- RGN_BITS, 16, number of upper HADDR bits compared (HADDR[31:32-RGN_BITS]).
- BASE_RGN, 16'hC000, region value of port 0. Port i decodes region BASE_RGN+i.
- PORT_EN, {NPORT{1'b1}}, per-port enable mask. A disabled port's region routes to the default slave.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL_M  in  1  master-level select for this address space.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- P_HSEL  out  NPORT  per-port address-phase select, one-hot or zero.
- P_HREADYOUT  in  NPORT  per-slave HREADYOUT.
- P_HRESP  in  NPORT  per-slave HRESP.
- P_HRDATA  in  32*NPORT  per-slave read data; port i occupies bits [32i+31:32i].
- HREADY  out  1  muxed ready, fed back to the master and to all slaves.
- HRESP  out  1  muxed response.
- HRDATA  out  32  muxed read data.
- ERR_CLR  in  1  synchronous clear of ERR_CNT and ERR_ADDR.
- ERR_CNT  out  ERR_CNT_W  saturating count of default-slave ERRORs.
- ERR_ADDR  out  32  HADDR of the most recent default-slave transfer.

Behaviour:
- Address decode (combinational):
  - hit[i] = HSEL_M && HADDR[31:32-RGN_BITS]==BASE_RGN+i.
  - P_HSEL[i] = hit[i] && PORT_EN[i].
  - def_sel = HSEL_M && no P_HSEL bit set.
- Elaboration check: elaboration fails if BASE_RGN+NPORT-1 exceeds 2^RGN_BITS-1. No wrap-around is allowed.
- Data-phase select register dsel[NPORT:0] (bit NPORT = default slave). Updated only when HREADY=1: dsel <= {def_sel, P_HSEL}. It holds while HREADY=0.
- Output mux:
  - dsel[i] set: HREADY=P_HREADYOUT[i], HRESP=P_HRESP[i], HRDATA=port i data.
  - dsel all zero: HREADY=1, HRESP=0, HRDATA=0.
  - dsel[NPORT] set: outputs come from the default slave.
- Default slave FSM, states IDLE/ERR1/ERR2:
  - IDLE: HREADYOUT=1, HRESP=0. If HREADY && def_sel && HTRANS[1], go to ERR1 and capture HADDR into ERR_ADDR.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Increment ERR_CNT, saturating at all-ones. Next state is ERR1 (with capture) if HREADY && def_sel && HTRANS[1]; otherwise IDLE.
  - IDLE or BUSY to the default slave gets a zero-wait OKAY.
- Default slave HRDATA=0.
- ERR_CLR: clears ERR_CNT and ERR_ADDR next edge. If ERR_CLR and an increment coincide, the clear wins and the count becomes 0.
- Reset values: dsel=0, FSM=IDLE, ERR_CNT=0, ERR_ADDR=0. Hence HREADY=1, HRESP=0, HRDATA=0.
- Reset mid-transfer: async clear of all state. The master sees HREADY=1 and OKAY immediately.
- Latency:
  - P_HSEL is zero-latency, combinational from HADDR.
  - Response selection lags one accepted address phase.
- Simultaneous events: a new address phase with HREADY=1 in the same cycle a slave completes is legal. dsel switches on that edge.

Decomposition:
- Shared package ahblite_pkg:
  - HTRANS encodings.
  - HRESP_OKAY/HRESP_ERROR.
  - default-slave state typedef.
- Sub-module ahblite_default_slave holds the FSM, error counter and address capture.
- The top holds decode, dsel and the mux.

Test Plan:
- Reset with HRESETn=0, then release → HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0, P_HSEL=0.
- NONSEQ read to 0xC002_0010, slave 2 returns 0xA5A5_0002 after 1 wait state → P_HSEL=4'b0100 in the address phase. HREADY is 0 for one cycle, then 1 with HRDATA=0xA5A5_0002.
- NONSEQ to 0xC004_0000 (unmapped) → P_HSEL=0. The response is HREADY=0/HRESP=1, then HREADY=1/HRESP=1. Afterwards ERR_CNT=1 and ERR_ADDR=0xC004_0000.
- PORT_EN=4'b1101, NONSEQ to 0xC001_0000 → P_HSEL=0, ERROR response, ERR_CNT increments.
- Back-to-back unmapped NONSEQs, 300 of them → ERR_CNT saturates at 255. ERR_CLR in the same cycle as an increment → ERR_CNT=0.
- IDLE transfer to 0xC009_0000 → zero-wait OKAY and ERR_CNT unchanged. Assert HRESETn low during ERR1 → HREADY=1 and HRESP=0 at once.
